// File: rtl/miner_pkg.sv
// Constants shared by the UART receive path, the header frame assembler and the miner core.
package miner_pkg;

    localparam int FRAME_BYTES        = 80;
    localparam int HEADER_W           = FRAME_BYTES * 8;
    localparam int CLOCK_HZ           = 50_000_000;
    // 100 ms of receive silence, expressed in clock cycles.
    localparam int DEFAULT_RX_TIMEOUT = CLOCK_HZ / 10;

endpackage

// File: rtl/header_frame_assembler_rising_edge_pulse.sv
// Single-cycle pulse on each rising edge of a level input.
// The history register has no reset, so a level held across reset is not seen as an edge.
module rising_edge_pulse (
    input  logic clock,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;

    // Track the previous level every cycle, reset or not.
    always_ff @(posedge clock) begin
        r_prev <= i_level;
    end

    assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/header_frame_assembler.sv
// Collects UART bytes into fixed-size block-header frames for the miner.
// Partial frames are dropped after an idle timeout; a newer frame always replaces an unconsumed one.
module header_frame_assembler #(
    parameter int FRAME_BYTES    = miner_pkg::FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = miner_pkg::DEFAULT_RX_TIMEOUT,
    parameter int DROP_CNT_W     = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [7:0]                         rx_byte,
    input  logic                               rx_strobe,
    output logic [FRAME_BYTES*8-1:0]           header_out,
    output logic                               header_valid,
    input  logic                               header_ready,
    output logic                               new_job,
    output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count,
    output logic                               rx_busy,
    output logic [DROP_CNT_W-1:0]              frame_drops
);

    localparam int HEADER_W = FRAME_BYTES * 8;
    localparam int CNT_W    = $clog2(FRAME_BYTES + 1);
    localparam int TMR_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic                  w_byte_event;
    logic [HEADER_W-9:0]   r_shift;
    logic [HEADER_W-1:0]   r_header;
    logic                  r_header_valid;
    logic                  r_new_job;
    logic [CNT_W-1:0]      r_byte_count;
    logic                  r_rx_busy;
    logic [TMR_W-1:0]      r_idle;
    logic [DROP_CNT_W-1:0] r_frame_drops;

    rising_edge_pulse u_strobe_edge (
        .clock   (clock),
        .i_level (rx_strobe),
        .o_pulse (w_byte_event)
    );

    // Byte collection, frame hand-off, idle timeout and drop accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift        <= '0;
            r_header       <= '0;
            r_header_valid <= 1'b0;
            r_new_job      <= 1'b0;
            r_byte_count   <= '0;
            r_rx_busy      <= 1'b0;
            r_idle         <= '0;
            r_frame_drops  <= '0;
        end else begin
            r_new_job <= 1'b0;
            if (r_header_valid && header_ready) begin
                r_header_valid <= 1'b0;
            end

            if (w_byte_event) begin
                r_idle <= '0;
                if (r_byte_count == LAST_BYTE) begin
                    // A fresh frame overrides any accept seen this same cycle.
                    r_header       <= {r_shift, rx_byte};
                    r_header_valid <= 1'b1;
                    r_new_job      <= 1'b1;
                    r_byte_count   <= '0;
                    r_rx_busy      <= 1'b0;
                end else begin
                    r_shift      <= {r_shift[HEADER_W-17:0], rx_byte};
                    r_byte_count <= r_byte_count + 1'b1;
                    r_rx_busy    <= 1'b1;
                end
            end else if (r_byte_count == '0) begin
                r_idle <= '0;
            end else if (r_idle == TIMER_LAST) begin
                r_idle       <= '0;
                r_byte_count <= '0;
                r_rx_busy    <= 1'b0;
                if (r_frame_drops != '1) begin
                    r_frame_drops <= r_frame_drops + 1'b1;
                end
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    assign header_out   = r_header;
    assign header_valid = r_header_valid;
    assign new_job      = r_new_job;
    assign byte_count   = r_byte_count;
    assign rx_busy      = r_rx_busy;
    assign frame_drops  = r_frame_drops;

endmodule
